// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The FIFO connects through the slave modport; the producer/consumer uses the master modport.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, data_in, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, data_in, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, occupancy count,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_param_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wp;
    logic [ADDR_WIDTH:0]   rp;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   ptr_gap;
    logic                  wr_ok;
    logic                  rd_ok;

    always_comb begin
        bus.full         = (cnt == DEPTH_C);
        bus.empty        = (cnt == '0);
        bus.almost_full  = (cnt >= AF_C);
        bus.almost_empty = (cnt <= AE_C);
        bus.count        = cnt;
        wr_ok            = bus.w_en && !bus.full;
        rd_ok            = bus.r_en && !bus.empty;
        ptr_gap          = wp - rp;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp[ADDR_WIDTH-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp            <= '0;
            rp            <= '0;
            cnt           <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A rejection in the same cycle as clr_err keeps the flag set.
            if (bus.w_en && bus.full) bus.overflow <= 1'b1;
            else if (bus.clr_err)     bus.overflow <= 1'b0;
            if (bus.r_en && bus.empty) bus.underflow <= 1'b1;
            else if (bus.clr_err)      bus.underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            always_comb begin
                bus.data_out = bus.empty ? '0 : mem[rp[ADDR_WIDTH-1:0]];
            end
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bus.data_out <= '0;
                end else if (rd_ok) begin
                    bus.data_out <= mem[rp[ADDR_WIDTH-1:0]];
                end
            end
        end
    endgenerate

    // Pointer distance must always agree with the registered occupancy.
    a_ptr_count: assert property (@(posedge clk) disable iff (rst) ptr_gap == cnt);
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one standard-read instance
// and one first-word-fall-through instance sharing clock and reset.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b_if ();

    sync_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4),
        .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)
    ) dut_std (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );

    sync_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4),
        .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle;
        a_if.w_en = 1'b0; a_if.r_en = 1'b0; a_if.clr_err = 1'b0; a_if.data_in = '0;
    endtask

    initial begin
        a_idle();
        b_if.w_en = 1'b0; b_if.r_en = 1'b0; b_if.clr_err = 1'b0; b_if.data_in = '0;
        #12 rst = 1'b0;
        #1;

        // Reset state
        check("rst_count", 32'(a_if.count), 32'd0);
        check("rst_empty", 32'(a_if.empty), 32'd1);
        check("rst_aempty", 32'(a_if.almost_empty), 32'd1);
        check("rst_full", 32'(a_if.full), 32'd0);
        check("rst_afull", 32'(a_if.almost_full), 32'd0);
        check("rst_dout", 32'(a_if.data_out), 32'd0);
        check("rst_ovf", 32'(a_if.overflow), 32'd0);
        check("rst_unf", 32'(a_if.underflow), 32'd0);

        // 1: fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            a_if.w_en = 1'b1; a_if.data_in = 8'(i);
            edge1();
            check("fill_count", 32'(a_if.count), 32'(i));
            check("fill_afull", 32'(a_if.almost_full), (i >= 14) ? 32'd1 : 32'd0);
            check("fill_aempty", 32'(a_if.almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            check("fill_full", 32'(a_if.full), (i == 16) ? 32'd1 : 32'd0);
        end
        a_if.data_in = 8'hFF;
        edge1();
        check("ovf_set", 32'(a_if.overflow), 32'd1);
        check("ovf_count", 32'(a_if.count), 32'd16);

        // 6: set beats clear, then clear alone
        a_if.clr_err = 1'b1;
        edge1();
        check("ovf_set_wins", 32'(a_if.overflow), 32'd1);
        a_if.w_en = 1'b0;
        edge1();
        check("ovf_cleared", 32'(a_if.overflow), 32'd0);
        a_if.clr_err = 1'b0;

        // 2: drain 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            a_if.r_en = 1'b1;
            edge1();
            check("drain_data", 32'(a_if.data_out), 32'(i));
            check("drain_count", 32'(a_if.count), 32'(16 - i));
            check("drain_aempty", 32'(a_if.almost_empty), (16 - i <= 2) ? 32'd1 : 32'd0);
        end
        check("drain_empty", 32'(a_if.empty), 32'd1);
        edge1();
        check("unf_set", 32'(a_if.underflow), 32'd1);
        check("unf_dout_hold", 32'(a_if.data_out), 32'h10);
        a_if.r_en = 1'b0; a_if.clr_err = 1'b1;
        edge1();
        check("unf_cleared", 32'(a_if.underflow), 32'd0);
        a_if.clr_err = 1'b0;

        // Read+write on empty: write taken, read rejected
        a_if.w_en = 1'b1; a_if.r_en = 1'b1; a_if.data_in = 8'h77;
        edge1();
        check("rw_empty_count", 32'(a_if.count), 32'd1);
        check("rw_empty_unf", 32'(a_if.underflow), 32'd1);
        check("rw_empty_dout", 32'(a_if.data_out), 32'h10);
        a_if.w_en = 1'b0;
        edge1();
        check("rw_empty_read", 32'(a_if.data_out), 32'h77);
        check("rw_empty_count0", 32'(a_if.count), 32'd0);
        a_idle();

        // 3: fill to 5 then 40 simultaneous cycles
        for (int i = 0; i < 5; i++) begin
            a_if.w_en = 1'b1; a_if.data_in = 8'(8'h20 + i);
            edge1();
        end
        check("pre_stream_count", 32'(a_if.count), 32'd5);
        for (int k = 0; k < 40; k++) begin
            a_if.w_en = 1'b1; a_if.r_en = 1'b1; a_if.data_in = 8'(8'h25 + k);
            edge1();
            check("stream_count", 32'(a_if.count), 32'd5);
            check("stream_data", 32'(a_if.data_out), 32'(8'h20 + k));
        end
        a_idle();

        // 5: count to 9, then async reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            a_if.w_en = 1'b1; a_if.data_in = 8'(8'h80 + i);
            edge1();
        end
        a_idle();
        check("pre_rst_count", 32'(a_if.count), 32'd9);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(a_if.count), 32'd0);
        check("arst_empty", 32'(a_if.empty), 32'd1);
        check("arst_dout", 32'(a_if.data_out), 32'd0);
        check("arst_ovf", 32'(a_if.overflow), 32'd0);
        check("arst_unf", 32'(a_if.underflow), 32'd0);
        #1 rst = 1'b0;
        a_if.w_en = 1'b1; a_if.data_in = 8'h5A;
        edge1();
        a_if.data_in = 8'h5B;
        edge1();
        a_if.w_en = 1'b0; a_if.r_en = 1'b1;
        edge1();
        check("post_rst_first", 32'(a_if.data_out), 32'h5A);
        check("post_rst_count", 32'(a_if.count), 32'd1);
        a_idle();

        // 4: FWFT instance
        b_if.w_en = 1'b1; b_if.data_in = 8'hA5;
        edge1();
        b_if.w_en = 1'b0;
        check("fwft_empty0", 32'(b_if.empty), 32'd0);
        check("fwft_head", 32'(b_if.data_out), 32'hA5);
        edge1();
        check("fwft_hold", 32'(b_if.data_out), 32'hA5);
        b_if.r_en = 1'b1;
        edge1();
        b_if.r_en = 1'b0;
        check("fwft_pop_empty", 32'(b_if.empty), 32'd1);
        check("fwft_pop_count", 32'(b_if.count), 32'd0);
        b_if.w_en = 1'b1; b_if.data_in = 8'h11;
        edge1();
        b_if.data_in = 8'h22;
        edge1();
        b_if.w_en = 1'b0;
        check("fwft_head2", 32'(b_if.data_out), 32'h11);
        b_if.r_en = 1'b1;
        edge1();
        b_if.r_en = 1'b0;
        check("fwft_next", 32'(b_if.data_out), 32'h22);
        check("fwft_next_count", 32'(b_if.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
